// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension stage: mode encodings and mode type.
// The optional JUMP mode is enabled by defining IMM_EXT_JUMP_EN.
package imm_ext_pkg;

  localparam int MODE_W = 3;

  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t MODE_ZERO   = 3'd0;
  localparam mode_t MODE_SIGN   = 3'd1;
  localparam mode_t MODE_BRANCH = 3'd2;
  localparam mode_t MODE_LUI    = 3'd3;
  localparam mode_t MODE_JUMP   = 3'd4;

  localparam int JIDX_W = 26;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational mode decode, immediate extension and next-PC computation.
// JUMP (mode 4) is legal only when IMM_EXT_JUMP_EN is defined.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic [MODE_W-1:0] mode,
  input  logic [IMM_W-1:0]  imm,
  input  logic [JIDX_W-1:0] jidx,
  input  logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] ext,
  output logic [DATA_W-1:0] target,
  output logic              err
);

  localparam int P = DATA_W - IMM_W;
  localparam logic [DATA_W-1:0] FOUR = DATA_W'(4);

  logic [DATA_W-1:0] pc4;

  assign pc4 = pc + FOUR;

`ifdef IMM_EXT_JUMP_EN
  logic [DATA_W-1:0] jump_target;

  // The jump keeps the region bits of pc+4 above bit 27.
  if (DATA_W > 28) begin : g_region
    assign jump_target = {pc4[DATA_W-1:28], jidx, 2'b00};
  end else begin : g_no_region
    assign jump_target = {jidx, 2'b00};
  end
`else
  logic unused_jidx;

  assign unused_jidx = ^jidx;
`endif

  // Illegal modes (and JUMP when disabled) fall to the default: ext=0, target=pc+4, err=1.
  always_comb begin
    ext    = '0;
    target = pc4;
    err    = 1'b0;
    case (mode)
      MODE_ZERO:   ext = {{P{1'b0}}, imm};
      MODE_SIGN:   ext = {{P{imm[IMM_W-1]}}, imm};
      MODE_BRANCH: begin
        ext    = {{(P-2){imm[IMM_W-1]}}, imm, 2'b00};
        target = pc4 + ext;
      end
      MODE_LUI:    ext = {imm, {P{1'b0}}};
`ifdef IMM_EXT_JUMP_EN
      MODE_JUMP:   target = jump_target;
`endif
      default:     err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_ext_unit.sv
// Registered immediate-extension / branch-target stage with a main register and 1-entry skid.
// Define IMM_EXT_JUMP_EN to make mode 4 (JUMP) legal.
module imm_ext_unit
  import imm_ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MODE_W-1:0] in_mode,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [JIDX_W-1:0] in_jidx,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_ext,
  output logic [DATA_W-1:0] out_target,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err
);

  // Widths depend on module parameters, so the payload type lives here rather than in the package.
  typedef struct packed {
    logic [DATA_W-1:0] ext;
    logic [DATA_W-1:0] target;
    logic [TAG_W-1:0]  tag;
    logic              err;
  } payload_t;

  logic [DATA_W-1:0] core_ext;
  logic [DATA_W-1:0] core_target;
  logic              core_err;
  payload_t          incoming;
  payload_t          main_q;
  payload_t          skid_q;
  logic              main_valid;
  logic              skid_valid;
  logic              accept_in;
  logic              drain;

  imm_ext_core #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W)
  ) u_core (
    .mode   (in_mode),
    .imm    (in_imm),
    .jidx   (in_jidx),
    .pc     (in_pc),
    .ext    (core_ext),
    .target (core_target),
    .err    (core_err)
  );

  always_comb begin
    incoming        = '0;
    incoming.ext    = core_ext;
    incoming.target = core_target;
    incoming.tag    = in_tag;
    incoming.err    = core_err;
  end

  assign in_ready  = ~skid_valid & ~rst;
  assign accept_in = in_valid & in_ready;
  assign drain     = ~main_valid | out_ready;

  // Main always holds the oldest entry; skid only fills while main is stalled, keeping FIFO order.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (drain) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= accept_in;
        if (accept_in) begin
          main_q <= incoming;
        end
      end
    end else if (accept_in) begin
      skid_q     <= incoming;
      skid_valid <= 1'b1;
    end
  end

  assign out_valid  = main_valid;
  assign out_ext    = main_q.ext;
  assign out_target = main_q.target;
  assign out_tag    = main_q.tag;
  assign out_err    = main_q.err;

endmodule

// File: tb/tb_imm_ext_unit.sv
// Self-checking bench for imm_ext_unit: directed cases then random traffic against a 2-deep FIFO model.
// Expectations follow IMM_EXT_JUMP_EN the same way the design does.
module tb_imm_ext_unit;

  localparam int DATA_W = 32;
  localparam int IMM_W  = 16;
  localparam int TAG_W  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_mode;
  logic [IMM_W-1:0]  in_imm;
  logic [25:0]       in_jidx;
  logic [DATA_W-1:0] in_pc;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_ext;
  logic [DATA_W-1:0] out_target;
  logic [TAG_W-1:0]  out_tag;
  logic              out_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] ext;
    logic [31:0] target;
    logic [4:0]  tag;
    logic        err;
  } exp_t;

  exp_t       q[$];
  logic [4:0] popped[$];
  logic       accepted;

  imm_ext_unit #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W),
    .TAG_W  (TAG_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mode    (in_mode),
    .in_imm     (in_imm),
    .in_jidx    (in_jidx),
    .in_pc      (in_pc),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ext    (out_ext),
    .out_target (out_target),
    .out_tag    (out_tag),
    .out_err    (out_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected entry from the mode rules, using plain arithmetic.
  function automatic exp_t refModel(input logic [2:0] mode, input logic [15:0] imm,
                                    input logic [25:0] jidx, input logic [31:0] pc,
                                    input logic [4:0] tag);
    exp_t        r;
    logic [31:0] pc4;
    logic [31:0] simm;
    pc4      = pc + 32'd4;
    simm     = (imm >= 16'h8000) ? ({16'h0, imm} - 32'h0001_0000) : {16'h0, imm};
    r.tag    = tag;
    r.err    = 1'b0;
    r.ext    = 32'h0;
    r.target = pc4;
    case (mode)
      3'd0: r.ext = {16'h0, imm};
      3'd1: r.ext = simm;
      3'd2: begin
        r.ext    = simm * 32'd4;
        r.target = pc4 + r.ext;
      end
      3'd3: r.ext = {16'h0, imm} * 32'h0001_0000;
`ifdef IMM_EXT_JUMP_EN
      3'd4: r.target = (pc4 & 32'hF000_0000) | ({6'h0, jidx} * 32'd4);
`else
      3'd4: r.err = 1'b1;
`endif
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", name, obs, expv);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare.
  task automatic applyStimulus(input logic r, input logic f, input logic v, input logic [2:0] m,
                               input logic [15:0] imm, input logic [25:0] j, input logic [31:0] pc,
                               input logic [4:0] tag, input logic ordy);
    logic acc_in;
    logic acc_out;
    exp_t e;
    rst       = r;
    flush     = f;
    in_valid  = v;
    in_mode   = m;
    in_imm    = imm;
    in_jidx   = j;
    in_pc     = pc;
    in_tag    = tag;
    out_ready = ordy;
    acc_in    = v && !r && (q.size() < 2);
    acc_out   = (q.size() > 0) && ordy;
    e         = refModel(m, imm, j, pc, tag);
    @(posedge clk);
    #1;
    if (r || f) begin
      q.delete();
    end else begin
      if (acc_out) begin
        popped.push_back(q[0].tag);
        void'(q.pop_front());
      end
      if (acc_in) q.push_back(e);
    end
    accepted = acc_in && !r && !f;
    checkOutput("out_valid", {31'h0, out_valid}, {31'h0, q.size() > 0});
    checkOutput("in_ready", {31'h0, in_ready}, {31'h0, !r && (q.size() < 2)});
    if (q.size() > 0) begin
      checkOutput("out_ext", out_ext, q[0].ext);
      checkOutput("out_target", out_target, q[0].target);
      checkOutput("out_tag", {27'h0, out_tag}, {27'h0, q[0].tag});
      checkOutput("out_err", {31'h0, out_err}, {31'h0, q[0].err});
    end
  endtask

  task automatic idle(input logic ordy);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 26'h0, 32'h0, 5'd0, ordy);
  endtask

  initial begin
    int sent;
    logic [4:0] want;

    $display("[TB] reset");
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 16'h0, 26'h0, 32'h0, 5'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 16'h0, 26'h0, 32'h0, 5'd0, 1'b1);
    checkOutput("rst_ext", out_ext, 32'h0);
    checkOutput("rst_target", out_target, 32'h0);
    checkOutput("rst_tag", {27'h0, out_tag}, 32'h0);
    checkOutput("rst_err", {31'h0, out_err}, 32'h0);
    idle(1'b1);
    checkOutput("rst_in_ready_after", {31'h0, in_ready}, 32'h1);

    $display("[TB] sign / branch");
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd1, 16'h8000, 26'h0, 32'h0000_1000, 5'd1, 1'b1);
    checkOutput("t1_sign_ext", out_ext, 32'hFFFF_8000);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd2, 16'hFFFF, 26'h0, 32'h0000_1000, 5'd2, 1'b1);
    checkOutput("t1_branch_ext", out_ext, 32'hFFFF_FFFC);
    checkOutput("t1_branch_target", out_target, 32'h0000_1000);

    $display("[TB] zero / lui");
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd0, 16'h8001, 26'h0, 32'h0000_2000, 5'd3, 1'b1);
    checkOutput("t2_zero_ext", out_ext, 32'h0000_8001);
    checkOutput("t2_zero_target", out_target, 32'h0000_2004);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd3, 16'h1234, 26'h0, 32'h0000_2004, 5'd4, 1'b1);
    checkOutput("t2_lui_ext", out_ext, 32'h1234_0000);
    checkOutput("t2_lui_target", out_target, 32'h0000_2008);
    idle(1'b1);

    $display("[TB] stream with stall");
    popped.delete();
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd1, 16'h0011, 26'h0, 32'h100, 5'd11, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd1, 16'h0012, 26'h0, 32'h104, 5'd12, 1'b0);
    checkOutput("t3_in_ready_low", {31'h0, in_ready}, 32'h0);
    checkOutput("t3_hold_tag", {27'h0, out_tag}, 32'd11);
    sent = 2;
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd1, 16'h0013, 26'h0, 32'h108, 5'd13, 1'b0);
    if (accepted) sent++;
    checkOutput("t3_hold_tag2", {27'h0, out_tag}, 32'd11);
    for (int i = 0; i < 10 && sent < 4; i++) begin
      want = 5'd11 + 5'(sent);
      applyStimulus(1'b0, 1'b0, 1'b1, 3'd1, 16'h0011 + 16'(sent), 26'h0, 32'h100, want, 1'b1);
      if (accepted) sent++;
    end
    checkOutput("t3_all_sent", 32'(sent), 32'd4);
    for (int i = 0; i < 4; i++) idle(1'b1);
    checkOutput("t3_out_count", 32'(popped.size()), 32'd4);
    for (int i = 0; i < 4 && i < popped.size(); i++)
      checkOutput("t3_order", {27'h0, popped[i]}, 32'd11 + 32'(i));

    $display("[TB] branch wrap");
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd2, 16'h0004, 26'h0, 32'hFFFF_FFF8, 5'd5, 1'b1);
    checkOutput("t4_wrap_target", out_target, 32'h0000_000C);

    $display("[TB] jump");
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd4, 16'h0000, 26'h0000010, 32'h3000_0000, 5'd6, 1'b1);
`ifdef IMM_EXT_JUMP_EN
    checkOutput("t5_jump_target", out_target, 32'h3000_0040);
    checkOutput("t5_jump_err", {31'h0, out_err}, 32'h0);
`else
    checkOutput("t5_jump_target", out_target, 32'h3000_0004);
    checkOutput("t5_jump_err", {31'h0, out_err}, 32'h1);
    checkOutput("t5_jump_ext", out_ext, 32'h0);
`endif
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd7, 16'h5555, 26'h0, 32'h0000_4000, 5'd7, 1'b1);
    checkOutput("t5_illegal_err", {31'h0, out_err}, 32'h1);
    checkOutput("t5_illegal_ext", out_ext, 32'h0);
    idle(1'b1);

    $display("[TB] flush while full");
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd0, 16'h0021, 26'h0, 32'h200, 5'd21, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd0, 16'h0022, 26'h0, 32'h204, 5'd22, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd0, 16'h0023, 26'h0, 32'h208, 5'd23, 1'b0);
    checkOutput("t6_flush_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("t6_flush_ready", {31'h0, in_ready}, 32'h1);
    idle(1'b1);
    checkOutput("t6_flush_stays_empty", {31'h0, out_valid}, 32'h0);

    $display("[TB] reset mid-stream");
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd1, 16'hF00F, 26'h0, 32'h300, 5'd25, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd1, 16'hF010, 26'h0, 32'h304, 5'd26, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd1, 16'hF011, 26'h0, 32'h308, 5'd27, 1'b1);
    checkOutput("t6_rst_ext", out_ext, 32'h0);
    checkOutput("t6_rst_target", out_target, 32'h0);
    checkOutput("t6_rst_tag", {27'h0, out_tag}, 32'h0);
    checkOutput("t6_rst_err", {31'h0, out_err}, 32'h0);
    idle(1'b1);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      logic [15:0] rimm;
      case ($urandom_range(0, 5))
        0:       rimm = 16'h8000;
        1:       rimm = 16'hFFFF;
        2:       rimm = 16'h7FFF;
        default: rimm = 16'($urandom);
      endcase
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 29) == 0,
                    $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), rimm,
                    26'($urandom), $urandom, 5'($urandom), $urandom_range(0, 2) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
